// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank
// Description : Bank of N_CH bidirectional I/O channels. Each channel has an
//               output FIFO (CPU pushes, external side pops through a
//               valid/ready handshake) and an input FIFO (external side
//               pushes through valid/ready, CPU pops). All FIFOs are
//               first-word fall-through and DEPTH x WIDTH. Misuse sets sticky
//               per-channel overflow/underflow flags and a bad-channel flag.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               cpu_ch            - channel addressed by every CPU operation
//               cpu_wr/cpu_wdata  - push into the selected output FIFO
//               cpu_rd/cpu_rdata  - pop / head of the selected input FIFO
//               cpu_out_full      - selected output FIFO full (1 if bad ch)
//               cpu_in_empty      - selected input FIFO empty (1 if bad ch)
//               out_data/valid/ready - per-channel output FIFO heads
//               in_data/valid/ready  - per-channel input FIFO feeds
//               err_ovf/unf/ch, err_clr - sticky error flags and their clear
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bank #(
   parameter int  WIDTH = 16,
   parameter int  N_CH  = 2,
   parameter int  DEPTH = 4,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CH_W-1:0]         cpu_ch,
   input  logic                    cpu_wr,
   input  logic [WIDTH-1:0]        cpu_wdata,
   input  logic                    cpu_rd,
   output logic [WIDTH-1:0]        cpu_rdata,
   output logic                    cpu_out_full,
   output logic                    cpu_in_empty,
   output logic [N_CH*WIDTH-1:0]   out_data,
   output logic [N_CH-1:0]         out_valid,
   input  logic [N_CH-1:0]         out_ready,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic [N_CH-1:0]         in_valid,
   output logic [N_CH-1:0]         in_ready,
   output logic [N_CH-1:0]         err_ovf,
   output logic [N_CH-1:0]         err_unf,
   output logic                    err_ch,
   input  logic                    err_clr
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic                        ch_ok_w;
   logic [N_CH-1:0]             sel_w;
   logic [N_CH-1:0]             out_full_w;
   logic [N_CH-1:0]             in_empty_w;
   logic [N_CH-1:0][WIDTH-1:0]  in_head_w;
   logic [N_CH-1:0]             ovf_set_w;
   logic [N_CH-1:0]             unf_set_w;
   logic                        ch_set_w;

   logic [N_CH-1:0]             err_ovf_q;
   logic [N_CH-1:0]             err_unf_q;
   logic                        err_ch_q;

   // cpu_ch may be wider than needed to encode N_CH, so out-of-range codes
   // must be caught explicitly.
   assign ch_ok_w  = (32'(cpu_ch) < 32'(N_CH));
   assign ch_set_w = (cpu_wr | cpu_rd) & ~ch_ok_w;

   generate
      for (genvar k = 0; k < N_CH; k++) begin : g_ch
         // ---------------- output FIFO (CPU -> external) ----------------
         logic [WIDTH-1:0] out_mem_q [DEPTH];
         logic [PTR_W-1:0] out_wptr_q;
         logic [PTR_W-1:0] out_rptr_q;
         logic [CNT_W-1:0] out_cnt_q;
         logic [CNT_W-1:0] out_cnt_d;
         logic             out_push_w;
         logic             out_pop_w;

         // ---------------- input FIFO (external -> CPU) -----------------
         logic [WIDTH-1:0] in_mem_q [DEPTH];
         logic [PTR_W-1:0] in_wptr_q;
         logic [PTR_W-1:0] in_rptr_q;
         logic [CNT_W-1:0] in_cnt_q;
         logic [CNT_W-1:0] in_cnt_d;
         logic             in_push_w;
         logic             in_pop_w;

         assign sel_w[k] = (32'(cpu_ch) == 32'(k));

         assign out_full_w[k] = (out_cnt_q == FULL_CNT);
         assign out_valid[k]  = (out_cnt_q != '0);
         // A push into a full FIFO is dropped even when a pop frees a slot
         // on the same edge, so fullness is judged on the current count.
         assign out_push_w    = cpu_wr & sel_w[k] & ~out_full_w[k];
         assign out_pop_w     = out_valid[k] & out_ready[k];
         assign ovf_set_w[k]  = cpu_wr & sel_w[k] & out_full_w[k];
         // Storage is not reset, so mask the head while empty.
         assign out_data[k*WIDTH +: WIDTH] = out_valid[k] ? out_mem_q[out_rptr_q] : '0;

         assign in_ready[k]   = (in_cnt_q != FULL_CNT);
         assign in_empty_w[k] = (in_cnt_q == '0);
         assign in_push_w     = in_valid[k] & in_ready[k];
         assign in_pop_w      = cpu_rd & sel_w[k] & ~in_empty_w[k];
         assign unf_set_w[k]  = cpu_rd & sel_w[k] & in_empty_w[k];
         assign in_head_w[k]  = in_empty_w[k] ? '0 : in_mem_q[in_rptr_q];

         always_comb begin
            out_cnt_d = out_cnt_q;
            if (out_push_w && !out_pop_w) begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end else if (!out_push_w && out_pop_w) begin
               out_cnt_d = out_cnt_q - CNT_W'(1);
            end
         end

         always_comb begin
            in_cnt_d = in_cnt_q;
            if (in_push_w && !in_pop_w) begin
               in_cnt_d = in_cnt_q + CNT_W'(1);
            end else if (!in_push_w && in_pop_w) begin
               in_cnt_d = in_cnt_q - CNT_W'(1);
            end
         end

         // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0
         // by plain binary overflow.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_wptr_q <= '0;
               out_rptr_q <= '0;
               out_cnt_q  <= '0;
               in_wptr_q  <= '0;
               in_rptr_q  <= '0;
               in_cnt_q   <= '0;
            end else begin
               if (out_push_w) out_wptr_q <= out_wptr_q + PTR_W'(1);
               if (out_pop_w)  out_rptr_q <= out_rptr_q + PTR_W'(1);
               out_cnt_q <= out_cnt_d;
               if (in_push_w)  in_wptr_q  <= in_wptr_q + PTR_W'(1);
               if (in_pop_w)   in_rptr_q  <= in_rptr_q + PTR_W'(1);
               in_cnt_q  <= in_cnt_d;
            end
         end

         always_ff @(posedge clk) begin
            if (out_push_w) out_mem_q[out_wptr_q] <= cpu_wdata;
            if (in_push_w)  in_mem_q[in_wptr_q]   <= in_data[k*WIDTH +: WIDTH];
         end
      end
   endgenerate

   // CPU-side status mux; an unmapped channel reads as full and empty.
   always_comb begin
      cpu_out_full = 1'b1;
      cpu_in_empty = 1'b1;
      cpu_rdata    = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel_w[k]) begin
            cpu_out_full = out_full_w[k];
            cpu_in_empty = in_empty_w[k];
            cpu_rdata    = in_head_w[k];
         end
      end
   end

   // Sticky errors: a new error on the same edge as err_clr wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf_q <= '0;
         err_unf_q <= '0;
         err_ch_q  <= 1'b0;
      end else begin
         err_ovf_q <= ovf_set_w | (err_ovf_q & {N_CH{~err_clr}});
         err_unf_q <= unf_set_w | (err_unf_q & {N_CH{~err_clr}});
         err_ch_q  <= ch_set_w  | (err_ch_q & ~err_clr);
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;
   assign err_ch  = err_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bank
// Description : Self-checking bench for io_port_bank (WIDTH=16, N_CH=3,
//               DEPTH=4). Directed vector table, asynchronous reset
//               sequence, then random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;
   localparam int W  = 16;
   localparam int NC = 3;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    cpu_ch = '0;
   logic          cpu_wr = 1'b0;
   logic [15:0]   cpu_wdata = '0;
   logic          cpu_rd = 1'b0;
   logic [15:0]   cpu_rdata;
   logic          cpu_out_full;
   logic          cpu_in_empty;
   logic [47:0]   out_data;
   logic [2:0]    out_valid;
   logic [2:0]    out_ready = '0;
   logic [47:0]   in_data = '0;
   logic [2:0]    in_valid = '0;
   logic [2:0]    in_ready;
   logic [2:0]    err_ovf;
   logic [2:0]    err_unf;
   logic          err_ch;
   logic          err_clr = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   io_port_bank #(.WIDTH(W), .N_CH(NC), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .cpu_ch(cpu_ch), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
      .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
      .cpu_out_full(cpu_out_full), .cpu_in_empty(cpu_in_empty),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .err_ovf(err_ovf), .err_unf(err_unf), .err_ch(err_ch), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------- directed vector table -------------------------
   typedef struct {
      logic [1:0]  ch;   logic wr; logic [15:0] wd; logic rd;
      logic [2:0]  ordy; logic [2:0] ivld; logic [15:0] id0; logic clr;
      logic [2:0]  e_ov; logic [2:0] e_ir; logic [15:0] e_h0; logic [15:0] e_h1;
      logic [15:0] e_rd; logic e_full; logic e_empty;
      logic [2:0]  e_ovf; logic [2:0] e_unf; logic e_ch;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] ch, input logic wr, input logic [15:0] wd,
                      input logic rd, input logic [2:0] ordy, input logic [2:0] ivld,
                      input logic [15:0] id0, input logic clr,
                      input logic [2:0] e_ov, input logic [2:0] e_ir,
                      input logic [15:0] e_h0, input logic [15:0] e_h1,
                      input logic [15:0] e_rd, input logic e_full, input logic e_empty,
                      input logic [2:0] e_ovf, input logic [2:0] e_unf, input logic e_ch);
      vec_t v;
      v.ch = ch; v.wr = wr; v.wd = wd; v.rd = rd; v.ordy = ordy; v.ivld = ivld;
      v.id0 = id0; v.clr = clr; v.e_ov = e_ov; v.e_ir = e_ir; v.e_h0 = e_h0;
      v.e_h1 = e_h1; v.e_rd = e_rd; v.e_full = e_full; v.e_empty = e_empty;
      v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_ch = e_ch;
      tbl.push_back(v);
   endtask

   // ------------------------- reference model -------------------------------
   logic [15:0] oq [3][$];
   logic [15:0] iq [3][$];
   logic [2:0]  m_ovf = '0;
   logic [2:0]  m_unf = '0;
   logic        m_ech = 1'b0;

   task automatic model_check();
      logic [47:0] e_od = '0;
      logic [2:0]  e_ov = '0;
      logic [2:0]  e_ir = '0;
      logic [15:0] e_rd = '0;
      logic        e_full = 1'b1;
      logic        e_empty = 1'b1;
      int          c = int'(cpu_ch);
      for (int k = 0; k < NC; k++) begin
         e_ov[k] = (oq[k].size() != 0);
         if (oq[k].size() != 0) e_od[k*16 +: 16] = oq[k][0];
         e_ir[k] = (iq[k].size() != D);
      end
      if (c < NC) begin
         e_full  = (oq[c].size() == D);
         e_empty = (iq[c].size() == 0);
         if (!e_empty) e_rd = iq[c][0];
      end
      chk("rnd_out_valid", 64'(out_valid), 64'(e_ov));
      chk("rnd_out_data", 64'(out_data), 64'(e_od));
      chk("rnd_in_ready", 64'(in_ready), 64'(e_ir));
      chk("rnd_cpu_rdata", 64'(cpu_rdata), 64'(e_rd));
      chk("rnd_cpu_out_full", 64'(cpu_out_full), 64'(e_full));
      chk("rnd_cpu_in_empty", 64'(cpu_in_empty), 64'(e_empty));
      chk("rnd_err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("rnd_err_unf", 64'(err_unf), 64'(m_unf));
      chk("rnd_err_ch", 64'(err_ch), 64'(m_ech));
   endtask

   // Applies one clock edge worth of traffic to the model.
   task automatic model_step();
      logic [2:0] ovf_s = '0;
      logic [2:0] unf_s = '0;
      for (int k = 0; k < NC; k++) begin
         int  osz = oq[k].size();
         int  isz = iq[k].size();
         logic sel = (int'(cpu_ch) == k);
         if (osz > 0 && out_ready[k]) void'(oq[k].pop_front());
         if (cpu_wr && sel) begin
            if (osz < D) oq[k].push_back(cpu_wdata);
            else         ovf_s[k] = 1'b1;
         end
         if (cpu_rd && sel) begin
            if (isz > 0) void'(iq[k].pop_front());
            else         unf_s[k] = 1'b1;
         end
         if (in_valid[k] && isz < D) iq[k].push_back(in_data[k*16 +: 16]);
      end
      m_ovf = ovf_s | (err_clr ? 3'b000 : m_ovf);
      m_unf = unf_s | (err_clr ? 3'b000 : m_unf);
      m_ech = ((cpu_wr || cpu_rd) && int'(cpu_ch) >= NC) | (err_clr ? 1'b0 : m_ech);
   endtask

   initial begin
      // ch wr wd rd ordy ivld id0 clr | ov ir h0 h1 rdata full empty ovf unf ech
      add(1,1,16'h1234,0,3'b000,3'b000,0,0, 3'b010,3'b111,16'h0000,16'h1234,0,0,1,0,0,0);
      add(1,1,16'hABCD,0,3'b000,3'b000,0,0, 3'b010,3'b111,16'h0000,16'h1234,0,0,1,0,0,0);
      add(1,0,16'h0000,0,3'b010,3'b000,0,0, 3'b010,3'b111,16'h0000,16'hABCD,0,0,1,0,0,0);
      add(1,0,16'h0000,0,3'b010,3'b000,0,0, 3'b000,3'b111,16'h0000,16'h0000,0,0,1,0,0,0);
      add(0,1,16'h0011,0,3'b000,3'b000,0,0, 3'b001,3'b111,16'h0011,0,0,0,1,0,0,0);
      add(0,1,16'h0022,0,3'b000,3'b000,0,0, 3'b001,3'b111,16'h0011,0,0,0,1,0,0,0);
      add(0,1,16'h0033,0,3'b000,3'b000,0,0, 3'b001,3'b111,16'h0011,0,0,0,1,0,0,0);
      add(0,1,16'h0044,0,3'b000,3'b000,0,0, 3'b001,3'b111,16'h0011,0,0,1,1,0,0,0);
      add(0,1,16'h0055,0,3'b000,3'b000,0,0, 3'b001,3'b111,16'h0011,0,0,1,1,3'b001,0,0);
      add(0,1,16'h0066,0,3'b001,3'b000,0,0, 3'b001,3'b111,16'h0022,0,0,0,1,3'b001,0,0);
      add(0,0,16'h0000,0,3'b001,3'b000,0,0, 3'b001,3'b111,16'h0033,0,0,0,1,3'b001,0,0);
      add(0,0,16'h0000,0,3'b001,3'b000,0,0, 3'b001,3'b111,16'h0044,0,0,0,1,3'b001,0,0);
      add(0,0,16'h0000,0,3'b001,3'b000,0,0, 3'b000,3'b111,16'h0000,0,0,0,1,3'b001,0,0);
      add(3,1,16'h7777,0,3'b000,3'b000,0,0, 3'b000,3'b111,0,0,0,1,1,3'b001,0,1);
      add(0,0,16'h0000,0,3'b000,3'b000,0,1, 3'b000,3'b111,0,0,0,0,1,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h0001,0, 3'b000,3'b111,0,0,16'h0001,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h0002,0, 3'b000,3'b111,0,0,16'h0001,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h0003,0, 3'b000,3'b111,0,0,16'h0001,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h0004,0, 3'b000,3'b110,0,0,16'h0001,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h0005,0, 3'b000,3'b110,0,0,16'h0001,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0002,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0003,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0004,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0000,0,1,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0000,0,1,0,3'b001,0);
      add(0,0,0,0,3'b000,3'b001,16'h00A1,1, 3'b000,3'b111,0,0,16'h00A1,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h00A2,0, 3'b000,3'b111,0,0,16'h00A1,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h00A3,0, 3'b000,3'b111,0,0,16'h00A1,0,0,0,0,0);
      add(0,0,0,0,3'b000,3'b001,16'h00A4,0, 3'b000,3'b110,0,0,16'h00A1,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b001,16'h00A5,0, 3'b000,3'b111,0,0,16'h00A2,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b001,16'h00A6,0, 3'b000,3'b111,0,0,16'h00A3,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h00A4,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h00A6,0,0,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,0,        3'b000,3'b111,0,0,16'h0000,0,1,0,0,0);
      add(0,0,0,1,3'b000,3'b000,0,1,        3'b000,3'b111,0,0,16'h0000,0,1,0,3'b001,0);
      add(0,0,0,0,3'b000,3'b000,0,1,        3'b000,3'b111,0,0,16'h0000,0,1,0,0,0);

      // ---------------- reset state ----------------
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(3'b000));
      chk("rst_in_ready", 64'(in_ready), 64'(3'b111));
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("rst_errors", 64'({err_ovf, err_unf, err_ch}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ---------------- directed table ----------------
      foreach (tbl[i]) begin
         cpu_ch = tbl[i].ch; cpu_wr = tbl[i].wr; cpu_wdata = tbl[i].wd;
         cpu_rd = tbl[i].rd; out_ready = tbl[i].ordy; in_valid = tbl[i].ivld;
         in_data = {32'h0, tbl[i].id0}; err_clr = tbl[i].clr;
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("v%0d_out_data0", i), 64'(out_data[15:0]), 64'(tbl[i].e_h0));
         chk($sformatf("v%0d_out_data1", i), 64'(out_data[31:16]), 64'(tbl[i].e_h1));
         chk($sformatf("v%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(tbl[i].e_rd));
         chk($sformatf("v%0d_cpu_out_full", i), 64'(cpu_out_full), 64'(tbl[i].e_full));
         chk($sformatf("v%0d_cpu_in_empty", i), 64'(cpu_in_empty), 64'(tbl[i].e_empty));
         chk($sformatf("v%0d_err_ovf", i), 64'(err_ovf), 64'(tbl[i].e_ovf));
         chk($sformatf("v%0d_err_unf", i), 64'(err_unf), 64'(tbl[i].e_unf));
         chk($sformatf("v%0d_err_ch", i), 64'(err_ch), 64'(tbl[i].e_ch));
      end
      cpu_wr = 0; cpu_rd = 0; out_ready = '0; in_valid = '0; err_clr = 0; in_data = '0;

      // ---------------- asynchronous reset mid-operation ----------------
      cpu_ch = 2; cpu_wr = 1; cpu_wdata = 16'h0B01;
      in_valid = 3'b010; in_data = 48'h0000_0C01_0000;
      @(posedge clk); #1;
      cpu_wdata = 16'h0B02; in_valid = '0;
      @(posedge clk); #1;
      cpu_wr = 0;
      chk("arst_pre_out_valid", 64'(out_valid), 64'(3'b100));
      chk("arst_pre_out_data2", 64'(out_data[47:32]), 64'(16'h0B01));
      cpu_ch = 1; #1;
      chk("arst_pre_in_empty1", 64'(cpu_in_empty), 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("arst_out_valid_now", 64'(out_valid), 64'(3'b000));
      chk("arst_in_empty_now", 64'(cpu_in_empty), 64'd1);
      chk("arst_out_data_now", 64'(out_data), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_post_out_valid", 64'(out_valid), 64'(3'b000));
      chk("arst_post_in_ready", 64'(in_ready), 64'(3'b111));
      chk("arst_post_in_empty1", 64'(cpu_in_empty), 64'd1);
      cpu_ch = 2; #1;
      chk("arst_post_out_full2", 64'(cpu_out_full), 64'd0);

      // ---------------- random traffic against the model ----------------
      for (int c = 0; c < 600; c++) begin
         cpu_ch    = 2'($urandom_range(0, 3));
         cpu_wr    = 1'($urandom_range(0, 1));
         cpu_rd    = 1'($urandom_range(0, 1));
         cpu_wdata = 16'($urandom);
         out_ready = (c < 300) ? 3'($urandom & $urandom) : 3'($urandom);
         in_valid  = 3'($urandom);
         in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
         err_clr   = ($urandom_range(0, 15) == 0);
         #1;
         model_check();
         @(posedge clk);
         model_step();
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
